// File: rtl/block_find_topk_if.sv
// Sample stream into and ranked-peak stream out of block_find_topk.
// The slave modport is the finder's side of the interface.
interface block_find_topk_if #(
    parameter int unsigned MSB_PHI = 7,
    parameter int unsigned MSB_R   = 11,
    parameter int unsigned MSB_CNT = 15,
    parameter int unsigned K       = 4
);
    localparam int unsigned RW = (K > 1) ? $clog2(K) : 1;

    logic               in_valid;
    logic [MSB_PHI:0]   in_phi;
    logic [MSB_R:0]     in_r;
    logic [MSB_CNT:0]   in_cnt;
    logic               in_last;

    logic               out_valid;
    logic               out_ready;
    logic [MSB_PHI:0]   out_phi;
    logic [MSB_R:0]     out_r;
    logic [MSB_CNT:0]   out_cnt;
    logic [RW-1:0]      out_rank;
    logic               out_last;

    modport master (
        output in_valid, in_phi, in_r, in_cnt, in_last, out_ready,
        input  out_valid, out_phi, out_r, out_cnt, out_rank, out_last
    );

    modport slave (
        input  in_valid, in_phi, in_r, in_cnt, in_last, out_ready,
        output out_valid, out_phi, out_r, out_cnt, out_rank, out_last
    );
endinterface

// File: rtl/block_find_topk.sv
// Keeps the K strongest angle-separated peaks of one accumulator scan in a sorted
// register list, then drains them in rank order over a valid/ready port.
module block_find_topk #(
    parameter int unsigned MSB_PHI  = 7,
    parameter int unsigned MSB_R    = 11,
    parameter int unsigned MSB_CNT  = 15,
    parameter int unsigned K        = 4,
    parameter int unsigned PHI_SEP  = 10,
    parameter int unsigned PHI_WRAP = 180,
    parameter int unsigned THRESH   = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    block_find_topk_if.slave       bus,
    output logic                   busy,
    output logic [$clog2(K+1)-1:0] num_peaks,
    output logic                   done
);
    localparam int unsigned RW = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned NW = $clog2(K + 1);
    localparam logic [MSB_PHI+1:0] WRAP_W   = (MSB_PHI + 2)'(PHI_WRAP);
    localparam logic [MSB_PHI+1:0] SEP_W    = (MSB_PHI + 2)'(PHI_SEP);
    localparam logic [MSB_CNT:0]   THRESH_W = (MSB_CNT + 1)'(THRESH);

    typedef enum logic [1:0] {StIdle, StScan, StDrain} state_e;

    state_e           state_q;
    logic [MSB_PHI:0] phi_q [K];
    logic [MSB_R:0]   r_q   [K];
    logic [MSB_CNT:0] cnt_q [K];
    logic [NW-1:0]    num_q;

    logic             out_valid_q;
    logic [MSB_PHI:0] out_phi_q;
    logic [MSB_R:0]   out_r_q;
    logic [MSB_CNT:0] out_cnt_q;
    logic [RW-1:0]    out_rank_q;
    logic             out_last_q;
    logic             done_q;

    // Survivors of neighbour removal, compacted, then the list with the sample inserted.
    logic [MSB_PHI:0] kp_phi  [K];
    logic [MSB_R:0]   kp_r    [K];
    logic [MSB_CNT:0] kp_cnt  [K];
    logic [MSB_PHI:0] ins_phi [K];
    logic [MSB_R:0]   ins_r   [K];
    logic [MSB_CNT:0] ins_cnt [K];
    logic [NW-1:0]    ins_num;

    logic [RW-1:0]    rank_nxt;
    logic             last_nxt;

    function automatic logic is_nb(input logic [MSB_PHI:0] a, input logic [MSB_PHI:0] b);
        logic [MSB_PHI+1:0] d;
        logic [MSB_PHI+1:0] w;
        d = (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
        w = '0;
        if (PHI_WRAP != 0 && d <= WRAP_W) begin
            w = WRAP_W - d;
            if (w < d) d = w;
        end
        return (PHI_SEP != 0) && (d < SEP_W);
    endfunction

    always_comb begin
        int   kc;
        int   pos;
        logic blocked;
        kc      = 0;
        pos     = 0;
        blocked = 1'b0;
        for (int i = 0; i < int'(K); i++) begin
            kp_phi[i]  = '0;
            kp_r[i]    = '0;
            kp_cnt[i]  = '0;
            ins_phi[i] = phi_q[i];
            ins_r[i]   = r_q[i];
            ins_cnt[i] = cnt_q[i];
        end
        ins_num = num_q;
        if (state_q == StScan && bus.in_valid && bus.in_cnt >= THRESH_W) begin
            for (int i = 0; i < int'(K); i++) begin
                if (i < int'(num_q)) begin
                    if (is_nb(phi_q[i], bus.in_phi)) begin
                        if (cnt_q[i] >= bus.in_cnt) blocked = 1'b1;
                    end else begin
                        kp_phi[kc] = phi_q[i];
                        kp_r[kc]   = r_q[i];
                        kp_cnt[kc] = cnt_q[i];
                        kc         = kc + 1;
                        // Survivors stay sorted, so this counts the slot the sample lands in.
                        if (cnt_q[i] >= bus.in_cnt) pos = pos + 1;
                    end
                end
            end
            if (!blocked && !(kc >= int'(K) && pos >= int'(K))) begin
                for (int j = 0; j < int'(K); j++) begin
                    if (j < pos) begin
                        ins_phi[j] = kp_phi[j];
                        ins_r[j]   = kp_r[j];
                        ins_cnt[j] = kp_cnt[j];
                    end else if (j == pos) begin
                        ins_phi[j] = bus.in_phi;
                        ins_r[j]   = bus.in_r;
                        ins_cnt[j] = bus.in_cnt;
                    end else begin
                        ins_phi[j] = kp_phi[j-1];
                        ins_r[j]   = kp_r[j-1];
                        ins_cnt[j] = kp_cnt[j-1];
                    end
                end
                ins_num = (kc >= int'(K)) ? NW'(K) : NW'(kc + 1);
            end
        end
    end

    assign rank_nxt = out_rank_q + RW'(1);
    assign last_nxt = (int'(out_rank_q) + 2 == int'(num_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            num_q       <= '0;
            out_valid_q <= 1'b0;
            out_phi_q   <= '0;
            out_r_q     <= '0;
            out_cnt_q   <= '0;
            out_rank_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            for (int i = 0; i < int'(K); i++) begin
                phi_q[i] <= '0;
                r_q[i]   <= '0;
                cnt_q[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StScan;
                        num_q   <= '0;
                        for (int i = 0; i < int'(K); i++) begin
                            phi_q[i] <= '0;
                            r_q[i]   <= '0;
                            cnt_q[i] <= '0;
                        end
                    end
                end
                StScan: begin
                    num_q <= ins_num;
                    for (int i = 0; i < int'(K); i++) begin
                        phi_q[i] <= ins_phi[i];
                        r_q[i]   <= ins_r[i];
                        cnt_q[i] <= ins_cnt[i];
                    end
                    if (bus.in_valid && bus.in_last) begin
                        if (ins_num != '0) begin
                            state_q     <= StDrain;
                            out_valid_q <= 1'b1;
                            out_phi_q   <= ins_phi[0];
                            out_r_q     <= ins_r[0];
                            out_cnt_q   <= ins_cnt[0];
                            out_rank_q  <= '0;
                            out_last_q  <= (ins_num == NW'(1));
                        end else begin
                            state_q <= StIdle;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (out_valid_q && bus.out_ready) begin
                        if (out_last_q) begin
                            state_q     <= StIdle;
                            done_q      <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_phi_q   <= '0;
                            out_r_q     <= '0;
                            out_cnt_q   <= '0;
                            out_rank_q  <= '0;
                            out_last_q  <= 1'b0;
                        end else begin
                            out_phi_q  <= phi_q[rank_nxt];
                            out_r_q    <= r_q[rank_nxt];
                            out_cnt_q  <= cnt_q[rank_nxt];
                            out_rank_q <= rank_nxt;
                            out_last_q <= last_nxt;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy          = (state_q != StIdle);
    assign num_peaks     = num_q;
    assign done          = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_phi   = out_phi_q;
    assign bus.out_r     = out_r_q;
    assign bus.out_cnt   = out_cnt_q;
    assign bus.out_rank  = out_rank_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_block_find_topk.sv
// Directed bench for block_find_topk: dut_a wraps phi at 180, dut_b has no wrap.
// Both see the same sample stream; dut_b always accepts its output.
module tb_block_find_topk;
    typedef logic [39:0] peak_t;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last  = 1'b0;
    logic        ready    = 1'b0;
    logic [7:0]  in_phi   = '0;
    logic [11:0] in_r     = '0;
    logic [15:0] in_cnt   = '0;
    logic        busy_a, done_a, busy_b, done_b;
    logic [2:0]  num_a, num_b;
    peak_t       obs_a, obs_b;
    int          n_checks = 0;
    int          n_fail   = 0;

    block_find_topk_if #(.MSB_PHI(7), .MSB_R(11), .MSB_CNT(15), .K(4)) ifa ();
    block_find_topk_if #(.MSB_PHI(7), .MSB_R(11), .MSB_CNT(15), .K(4)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_phi    = in_phi;
    assign ifa.in_r      = in_r;
    assign ifa.in_cnt    = in_cnt;
    assign ifa.in_last   = in_last;
    assign ifa.out_ready = ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_phi    = in_phi;
    assign ifb.in_r      = in_r;
    assign ifb.in_cnt    = in_cnt;
    assign ifb.in_last   = in_last;
    assign ifb.out_ready = 1'b1;

    block_find_topk #(
        .MSB_PHI(7), .MSB_R(11), .MSB_CNT(15), .K(4), .PHI_SEP(10), .PHI_WRAP(180), .THRESH(8)
    ) dut_a (
        .clk(clk), .reset(reset), .start(start), .bus(ifa.slave),
        .busy(busy_a), .num_peaks(num_a), .done(done_a)
    );

    block_find_topk #(
        .MSB_PHI(7), .MSB_R(11), .MSB_CNT(15), .K(4), .PHI_SEP(10), .PHI_WRAP(0), .THRESH(8)
    ) dut_b (
        .clk(clk), .reset(reset), .start(start), .bus(ifb.slave),
        .busy(busy_b), .num_peaks(num_b), .done(done_b)
    );

    always #5 clk = ~clk;

    assign obs_a = {ifa.out_valid, ifa.out_phi, ifa.out_r, ifa.out_cnt, ifa.out_rank,
                    ifa.out_last};
    assign obs_b = {ifb.out_valid, ifb.out_phi, ifb.out_r, ifb.out_cnt, ifb.out_rank,
                    ifb.out_last};

    function automatic peak_t pk(input logic v, input int phi, input int r, input int cnt,
                                 input int rank, input logic last);
        return {v, 8'(phi), 12'(r), 16'(cnt), 2'(rank), last};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_frame();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int phi, input int r, input int cnt, input logic last);
        in_valid = 1'b1;
        in_phi   = 8'(phi);
        in_r     = 12'(r);
        in_cnt   = 16'(cnt);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (obs_a !== pk(0, 0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_out_a: got %h want %h", obs_a, pk(0, 0, 0, 0, 0, 0));
        end
        n_checks++;
        if ({busy_a, done_a, num_a} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_status_a: got %b want 00000", {busy_a, done_a, num_a});
        end
        n_checks++;
        if ({obs_b, busy_b, done_b, num_b} !== 45'b0) begin
            n_fail++;
            $display("FAIL reset_b: got %h want 0", {obs_b, busy_b, done_b, num_b});
        end
    endtask

    task automatic test_basic();
        peak_t exp[3];
        exp[0] = pk(1, 150, 50, 70, 0, 0);
        exp[1] = pk(1, 25, 110, 60, 1, 0);
        exp[2] = pk(1, 90, 300, 40, 2, 1);
        begin_frame();
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b want 1", busy_a);
        end
        send(20, 100, 50, 0);
        n_checks++;
        if (num_a !== 3'd1) begin
            n_fail++;
            $display("FAIL basic_num_first: got %0d want 1", num_a);
        end
        send(25, 110, 60, 0);
        n_checks++;
        if (num_a !== 3'd1) begin
            n_fail++;
            $display("FAIL basic_num_replace: got %0d want 1", num_a);
        end
        send(90, 300, 40, 0);
        send(150, 50, 70, 0);
        send(155, 60, 30, 0);
        n_checks++;
        if (num_a !== 3'd3) begin
            n_fail++;
            $display("FAIL basic_num_suppress: got %0d want 3", num_a);
        end
        send(100, 200, 5, 1);
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_a !== exp[k]) begin
                n_fail++;
                $display("FAIL basic_rank%0d: got %h want %h", k, obs_a, exp[k]);
            end
            n_checks++;
            if (num_a !== 3'd3) begin
                n_fail++;
                $display("FAIL basic_num_drain%0d: got %0d want 3", k, num_a);
            end
            tick();
        end
        n_checks++;
        if ({done_a, busy_a, ifa.out_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_done: got %b want 100", {done_a, busy_a, ifa.out_valid});
        end
        tick();
        n_checks++;
        if (done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_pulse: got %b want 0", done_a);
        end
        ready = 1'b0;
        tick();
    endtask

    task automatic test_overflow();
        peak_t exp[4];
        exp[0] = pk(1, 45, 7, 100, 0, 0);
        exp[1] = pk(1, 150, 6, 60, 1, 0);
        exp[2] = pk(1, 120, 5, 50, 2, 0);
        exp[3] = pk(1, 90, 4, 40, 3, 1);
        begin_frame();
        for (int i = 0; i < 6; i++) send(30 * i, i + 1, 10 * (i + 1), 0);
        send(45, 7, 100, 0);
        send(0, 9, 40, 1);
        ready = 1'b1;
        n_checks++;
        if (num_a !== 3'd4) begin
            n_fail++;
            $display("FAIL overflow_num: got %0d want 4", num_a);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_a !== exp[k]) begin
                n_fail++;
                $display("FAIL overflow_rank%0d: got %h want %h", k, obs_a, exp[k]);
            end
            tick();
        end
        n_checks++;
        if (done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_done: got %b want 1", done_a);
        end
        tick();
        // Sample at 45 sits within separation of both 40 and 50.
        begin_frame();
        send(40, 1, 20, 0);
        send(50, 2, 30, 0);
        send(100, 3, 10, 0);
        n_checks++;
        if (num_a !== 3'd3) begin
            n_fail++;
            $display("FAIL multi_num_before: got %0d want 3", num_a);
        end
        send(45, 4, 40, 1);
        n_checks++;
        if (num_a !== 3'd2) begin
            n_fail++;
            $display("FAIL multi_num_after: got %0d want 2", num_a);
        end
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (obs_a !== ((k == 0) ? pk(1, 45, 4, 40, 0, 0) : pk(1, 100, 3, 10, 1, 1))) begin
                n_fail++;
                $display("FAIL multi_rank%0d: got %h", k, obs_a);
            end
            tick();
        end
        ready = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        peak_t exp[3];
        begin_frame();
        send(178, 5, 40, 0);
        send(3, 6, 50, 1);
        n_checks++;
        if (obs_a !== pk(1, 3, 6, 50, 0, 1) || num_a !== 3'd1) begin
            n_fail++;
            $display("FAIL wrap_a: got %h num %0d want %h num 1", obs_a, num_a,
                     pk(1, 3, 6, 50, 0, 1));
        end
        n_checks++;
        if (obs_b !== pk(1, 3, 6, 50, 0, 0) || num_b !== 3'd2) begin
            n_fail++;
            $display("FAIL nowrap_r0: got %h num %0d want %h num 2", obs_b, num_b,
                     pk(1, 3, 6, 50, 0, 0));
        end
        ready = 1'b1;
        tick();
        n_checks++;
        if (done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_done: got %b want 1", done_a);
        end
        n_checks++;
        if (obs_b !== pk(1, 178, 5, 40, 1, 1)) begin
            n_fail++;
            $display("FAIL nowrap_r1: got %h want %h", obs_b, pk(1, 178, 5, 40, 1, 1));
        end
        tick();
        n_checks++;
        if (done_b !== 1'b1) begin
            n_fail++;
            $display("FAIL nowrap_done: got %b want 1", done_b);
        end
        tick();
        // Tie with a neighbour keeps the earlier entry; distance equal to separation is kept.
        exp[0] = pk(1, 10, 1, 40, 0, 0);
        exp[1] = pk(1, 20, 3, 40, 1, 0);
        exp[2] = pk(1, 30, 4, 40, 2, 1);
        begin_frame();
        send(10, 1, 40, 0);
        send(15, 2, 40, 0);
        send(20, 3, 40, 0);
        send(30, 4, 40, 1);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (obs_a !== exp[k]) begin
                n_fail++;
                $display("FAIL tie_rank%0d: got %h want %h", k, obs_a, exp[k]);
            end
            tick();
        end
        ready = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        peak_t exp[4];
        exp[0] = pk(1, 10, 1, 80, 0, 0);
        exp[1] = pk(1, 50, 2, 70, 1, 0);
        exp[2] = pk(1, 90, 3, 60, 2, 0);
        exp[3] = pk(1, 130, 4, 50, 3, 1);
        begin_frame();
        send(10, 1, 80, 0);
        send(50, 2, 70, 0);
        send(90, 3, 60, 0);
        send(130, 4, 50, 1);
        for (int k = 0; k < 4; k++) begin
            ready = 1'b0;
            n_checks++;
            if (obs_a !== exp[k]) begin
                n_fail++;
                $display("FAIL bp_rank%0d: got %h want %h", k, obs_a, exp[k]);
            end
            tick();
            n_checks++;
            if (obs_a !== exp[k]) begin
                n_fail++;
                $display("FAIL bp_stall%0d: got %h want %h", k, obs_a, exp[k]);
            end
            ready = 1'b1;
            tick();
        end
        ready = 1'b0;
        n_checks++;
        if ({done_a, ifa.out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_done: got %b want 10", {done_a, ifa.out_valid});
        end
        tick();
    endtask

    task automatic test_empty();
        begin_frame();
        send(10, 1, 3, 0);
        n_checks++;
        if ({ifa.out_valid, busy_a, num_a} !== 5'b01000) begin
            n_fail++;
            $display("FAIL empty_scan: got %b want 01000", {ifa.out_valid, busy_a, num_a});
        end
        send(50, 2, 7, 1);
        n_checks++;
        if ({ifa.out_valid, busy_a, done_a, num_a} !== 6'b001000) begin
            n_fail++;
            $display("FAIL empty_done: got %b want 001000",
                     {ifa.out_valid, busy_a, done_a, num_a});
        end
        // Start is taken in the done cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy_a, done_a} !== 2'b10) begin
            n_fail++;
            $display("FAIL empty_restart: got %b want 10", {busy_a, done_a});
        end
        send(0, 0, 0, 1);
        n_checks++;
        if ({ifa.out_valid, busy_a, done_a} !== 3'b001) begin
            n_fail++;
            $display("FAIL empty_done2: got %b want 001", {ifa.out_valid, busy_a, done_a});
        end
        tick();
        n_checks++;
        if (done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_done_pulse: got %b want 0", done_a);
        end
    endtask

    task automatic test_reset_mid_drain();
        begin_frame();
        send(10, 1, 80, 0);
        send(50, 2, 70, 0);
        send(90, 3, 60, 0);
        send(130, 4, 50, 1);
        ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (obs_a !== pk(1, 90, 3, 60, 2, 0)) begin
            n_fail++;
            $display("FAIL rst_pre: got %h want %h", obs_a, pk(1, 90, 3, 60, 2, 0));
        end
        reset = 1'b1;
        ready = 1'b0;
        tick();
        n_checks++;
        if ({obs_a, busy_a, done_a, num_a} !== 45'b0) begin
            n_fail++;
            $display("FAIL rst_outputs: got %h want 0", {obs_a, busy_a, done_a, num_a});
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({busy_a, done_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_no_done: got %b want 00", {busy_a, done_a});
        end
        begin_frame();
        send(60, 9, 99, 1);
        n_checks++;
        if (obs_a !== pk(1, 60, 9, 99, 0, 1) || num_a !== 3'd1) begin
            n_fail++;
            $display("FAIL rst_new_frame: got %h num %0d want %h num 1", obs_a, num_a,
                     pk(1, 60, 9, 99, 0, 1));
        end
        ready = 1'b1;
        tick();
        n_checks++;
        if (done_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_new_done: got %b want 1", done_a);
        end
        ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_wrap();
        test_backpressure();
        test_empty();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
